aes_pkcs7_padder: RTL

Streaming PKCS#7 padder between the message word source and the AES block engine. It consumes 128-bit message words with sop/eop/empty framing and replaces the unused tail bytes of the final word with PKCS#7 pad bytes. When the final word is completely full, it appends one extra all-pad block. It emits only full 128-bit blocks with sop/eop framing, through a single registered output stage with valid/ready backpressure.

---
 rtl/aes_pkcs7_padder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/aes_pkcs7_padder.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkcs7_padder
// Purpose  : Streaming PKCS#7 padder feeding the AES block engine. Replaces
//            unused tail bytes of the final message word with pad bytes,
//            appends a full pad block when the final word is completely
//            full, and presents full 128-bit blocks through a single
//            registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module aes_pkcs7_padder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             msg_in_valid,
   input  logic [127:0]     msg_in_data,
   input  logic             msg_in_sop,
   input  logic             msg_in_eop,
   input  logic [6:0]       msg_in_empty,
   output logic             msg_in_ready,
   output logic             blk_out_valid,
   output logic [127:0]     blk_out_data,
   output logic             blk_out_sop,
   output logic             blk_out_eop,
   input  logic             blk_out_ready,
   output logic [CNT_W-1:0] msg_cnt,
   output logic             proto_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BODY = 2'd1,
      ST_PAD  = 2'd2
   } state_t;

   localparam logic [127:0] FULL_PAD_BLOCK = {16{8'h10}};

   state_t             state_q;
   logic               valid_q;
   logic [127:0]       data_q;
   logic               sop_q;
   logic               eop_q;
   logic [CNT_W-1:0]   msg_cnt_q;
   logic               proto_err_q;

   logic               out_free;
   logic               accept;
   logic               out_hs;
   logic [4:0]         pad_len;
   logic [127:0]       padded_data;

   // The output register may load when it is empty or being drained this cycle.
   assign out_free     = ~valid_q | blk_out_ready;
   assign msg_in_ready = out_free & (state_q != ST_PAD);
   assign accept       = msg_in_valid & msg_in_ready;
   assign out_hs       = valid_q & blk_out_ready;

   assign blk_out_valid = valid_q;
   assign blk_out_data  = data_q;
   assign blk_out_sop   = sop_q;
   assign blk_out_eop   = eop_q;
   assign msg_cnt       = msg_cnt_q;
   assign proto_err     = proto_err_q;

   // Clamp empty to one block and overwrite the low pad_len bytes with pad_len.
   always_comb begin
      pad_len     = (msg_in_empty >= 7'd16) ? 5'd16 : msg_in_empty[4:0];
      padded_data = msg_in_data;
      for (int i = 0; i < 16; i++) begin
         if (5'(i) < pad_len) begin
            padded_data[8*i +: 8] = {3'b000, pad_len};
         end
      end
   end

   // Framing state machine, registered output stage, message counter and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         valid_q     <= 1'b0;
         data_q      <= '0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         msg_cnt_q   <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (out_hs && eop_q) begin
            msg_cnt_q <= msg_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end

         if (state_q == ST_PAD) begin
            // The owed pad block waits until the final word has been taken.
            if (out_free) begin
               valid_q <= 1'b1;
               data_q  <= FULL_PAD_BLOCK;
               sop_q   <= 1'b0;
               eop_q   <= 1'b1;
               state_q <= ST_IDLE;
            end
         end else if (accept) begin
            if ((state_q == ST_IDLE) && !msg_in_sop) begin
               // Orphan beat outside a message: swallow it and flag it.
               proto_err_q <= 1'b1;
               valid_q     <= 1'b0;
            end else begin
               // A sop inside a message is flagged but the beat continues the message.
               if ((state_q == ST_BODY) && msg_in_sop) begin
                  proto_err_q <= 1'b1;
               end
               valid_q <= 1'b1;
               sop_q   <= msg_in_sop;
               if (!msg_in_eop) begin
                  data_q  <= msg_in_data;
                  eop_q   <= 1'b0;
                  state_q <= ST_BODY;
               end else if (pad_len == 5'd0) begin
                  data_q  <= msg_in_data;
                  eop_q   <= 1'b0;
                  state_q <= ST_PAD;
               end else begin
                  data_q  <= padded_data;
                  eop_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
         end else if (out_free) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
